// File: rtl/spi_adc_responder.sv
// SPI mode-0 target emulating a serial ADC for loopback bring-up.
// Sends a header then a DATA_W-bit sample, MSB first, per cs_n frame.
//
// Ports:
//   clk          system clock, at least 8x the sck rate
//   reset        asynchronous, active-high
//   sample_in    sample written into the one-entry holding buffer
//   sample_valid one-cycle load strobe for sample_in
//   sck, cs_n    SPI clock and chip select from the controller (async)
//   miso         serial data to the controller
//   miso_oe      high while the synchronised cs_n is low
//   busy         frame in progress
//   frame_done   one-cycle pulse once the last frame bit is clocked
//   fresh        holding buffer holds a sample not yet sent
//   stale        sticky flag: a frame started with no fresh sample
//
// Build option: define SPI_RESP_STALE_FLAG_EN to enable the stale flag
// and send the header as ones in stale frames. Otherwise stale is 0
// and the header is always zeros.
`timescale 1ns/1ps
module spi_adc_responder #(
    parameter int DATA_W      = 10,
    parameter int LEAD_ZEROS  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              sck,
    input  logic              cs_n,
    output logic              miso,
    output logic              miso_oe,
    output logic              busy,
    output logic              frame_done,
    output logic              fresh,
    output logic              stale
);

    localparam int FRAME_BITS = LEAD_ZEROS + DATA_W;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sck_sync;
    logic [SYNC_STAGES-1:0]  cs_sync;
    logic                    sck_q;
    logic                    cs_q;
    logic                    sck_rise;
    logic                    sck_fall;
    logic                    cs_rise;
    logic                    cs_fall;
    logic                    frame_start;
    logic                    hdr_bit;
    logic [DATA_W-1:0]       hold_buf;
    logic [FRAME_BITS-1:0]   shreg;
    logic [FRAME_BITS-1:0]   load_word;
    logic [CNT_W-1:0]        cnt;

    // Synchronisers idle at sck=0, cs_n=1 so reset release
    // never looks like the start of a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync <= '0;
            cs_sync  <= '1;
            sck_q    <= 1'b0;
            cs_q     <= 1'b1;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sck_q    <= sck_sync[SYNC_STAGES-1];
            cs_q     <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sck_rise = sck_sync[SYNC_STAGES-1] & ~sck_q;
    assign sck_fall = ~sck_sync[SYNC_STAGES-1] & sck_q;
    assign cs_rise  = cs_sync[SYNC_STAGES-1] & ~cs_q;
    assign cs_fall  = ~cs_sync[SYNC_STAGES-1] & cs_q;

    assign frame_start = (state == IDLE) && cs_fall;
    assign load_word   = {{LEAD_ZEROS{hdr_bit}}, hold_buf};

`ifdef SPI_RESP_STALE_FLAG_EN
    assign hdr_bit = ~fresh;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stale <= 1'b0;
        end else if (frame_start && !fresh) begin
            stale <= 1'b1;
        end
    end
`else
    assign hdr_bit = 1'b0;
    assign stale   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hold_buf   <= '0;
            shreg      <= '0;
            cnt        <= '0;
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            fresh      <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // A load in the frame-start cycle wins over the clear:
            // the frame takes the old value, the new one stays fresh.
            if (sample_valid) begin
                hold_buf <= sample_in;
                fresh    <= 1'b1;
            end else if (frame_start) begin
                fresh    <= 1'b0;
            end

            if (cs_rise) begin
                state   <= IDLE;
                miso    <= 1'b0;
                miso_oe <= 1'b0;
                busy    <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            shreg   <= load_word;
                            miso    <= load_word[FRAME_BITS-1];
                            cnt     <= '0;
                            busy    <= 1'b1;
                            miso_oe <= 1'b1;
                            state   <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (sck_rise) begin
                            cnt <= cnt + 1'b1;
                            if (cnt == CNT_LAST) begin
                                frame_done <= 1'b1;
                                state      <= DONE;
                            end
                        end else if (sck_fall && cnt < CNT_FULL) begin
                            shreg <= shreg << 1;
                            miso  <= shreg[FRAME_BITS-2];
                        end
                    end
                    DONE: begin
                        // Counter holds at FRAME_BITS; extra clocks read 0.
                        if (sck_rise || sck_fall) begin
                            miso <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_adc_responder.sv
// Randomised scoreboard bench for spi_adc_responder.
// Acts as a mode-0 SPI controller against a frame-level model.
`timescale 1ns/1ps
module tb_spi_adc_responder;

    localparam int DATA_W      = 10;
    localparam int LEAD_ZEROS  = 2;
    localparam int SYNC_STAGES = 2;
    localparam int FRAME_BITS  = DATA_W + LEAD_ZEROS;
`ifdef SPI_RESP_STALE_FLAG_EN
    localparam bit STALE_EN = 1'b1;
`else
    localparam bit STALE_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] sample_in = '0;
    logic              sample_valid = 1'b0;
    logic              sck = 1'b0;
    logic              cs_n = 1'b1;
    logic              miso;
    logic              miso_oe;
    logic              busy;
    logic              frame_done;
    logic              fresh;
    logic              stale;

    int checks = 0;
    int failures = 0;
    int fd_count = 0;

    logic [FRAME_BITS-1:0] exp_q[$];
    logic [FRAME_BITS-1:0] cap_word = '0;

    // Frame-level reference model state.
    int m_buf = 0;
    bit m_fresh = 1'b0;
    bit m_stale = 1'b0;

    always #5 clk = ~clk;

    spi_adc_responder #(
        .DATA_W(DATA_W),
        .LEAD_ZEROS(LEAD_ZEROS),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sample_in(sample_in),
        .sample_valid(sample_valid),
        .sck(sck),
        .cs_n(cs_n),
        .miso(miso),
        .miso_oe(miso_oe),
        .busy(busy),
        .frame_done(frame_done),
        .fresh(fresh),
        .stale(stale)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_start();
        int hdr;
        hdr = 0;
        if (STALE_EN && !m_fresh) begin
            hdr = (1 << LEAD_ZEROS) - 1;
            m_stale = 1'b1;
        end
        m_fresh = 1'b0;
        return hdr * (1 << DATA_W) + m_buf;
    endfunction

    task automatic load(input int v);
        @(negedge clk);
        sample_in = DATA_W'(v);
        sample_valid = 1'b1;
        m_buf = v;
        m_fresh = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        check("fresh_after_load", 32'(fresh), 1);
    endtask

    task automatic run_frame(input int n_rises, input bit load_mid,
                             input int load_val,
                             output logic [31:0] bits);
        int word;
        int fd0;
        int extra;
        word = model_start();
        if (load_mid) begin
            m_buf = load_val;
            m_fresh = 1'b1;
        end
        if (n_rises >= FRAME_BITS)
            exp_q.push_back(FRAME_BITS'(word));
        fd0 = fd_count;
        bits = '0;
        @(negedge clk);
        cs_n = 1'b0;
        cap_word = '0;
        @(negedge clk);
        @(negedge clk);
        check("oe_latency_early", 32'(miso_oe), 0);
        if (load_mid) begin
            sample_in = DATA_W'(load_val);
            sample_valid = 1'b1;
        end
        @(negedge clk);
        sample_valid = 1'b0;
        check("oe_latency", 32'(miso_oe), 1);
        check("busy_in_frame", 32'(busy), 1);
        @(negedge clk);
        for (int i = 0; i < n_rises; i++) begin
            sck = 1'b1;
            bits = {bits[30:0], miso};
            cap_word = {cap_word[FRAME_BITS-2:0], miso};
            repeat (4) @(negedge clk);
            sck = 1'b0;
            repeat (4) @(negedge clk);
        end
        cs_n = 1'b1;
        repeat (4) @(negedge clk);
        check("busy_after", 32'(busy), 0);
        check("miso_after", 32'(miso), 0);
        check("oe_after", 32'(miso_oe), 0);
        check("frame_done_count", fd_count - fd0,
              (n_rises >= FRAME_BITS) ? 1 : 0);
        if (n_rises < FRAME_BITS) begin
            check("abort_prefix", bits, word >> (FRAME_BITS - n_rises));
        end else begin
            extra = n_rises - FRAME_BITS;
            check("extra_bits_zero", bits & ((1 << extra) - 1), 0);
            check("frame_bits", bits >> extra, word);
        end
        check("fresh_after_frame", 32'(fresh), 32'(m_fresh));
        check("stale_after_frame", 32'(stale), 32'(m_stale));
    endtask

    // Monitor: every frame_done pops the next expected frame.
    initial begin : monitor
        logic [FRAME_BITS-1:0] e;
        forever begin
            @(negedge clk);
            if (frame_done) begin
                fd_count++;
                if (exp_q.size() == 0) begin
                    check("frame_done_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("scoreboard_word", 32'(cap_word), 32'(e));
                end
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL timeout: sim still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] bits;
        int n;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            sck = ~sck;
            cs_n = ~cs_n;
        end
        check("rst_miso", 32'(miso), 0);
        check("rst_oe", 32'(miso_oe), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_fresh", 32'(fresh), 0);
        check("rst_stale", 32'(stale), 0);
        @(negedge clk);
        sck = 1'b0;
        cs_n = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rel_miso", 32'(miso), 0);
        check("rel_busy", 32'(busy), 0);

        load('h2A5);
        run_frame(FRAME_BITS, 1'b0, 0, bits);

        load('h3FF);
        run_frame(5, 1'b0, 0, bits);
        check("fresh_after_abort", 32'(fresh), 0);
        run_frame(FRAME_BITS, 1'b0, 0, bits);

        load('h0AA);
        run_frame(FRAME_BITS, 1'b1, 'h155, bits);
        check("fresh_simul_load", 32'(fresh), 1);
        run_frame(FRAME_BITS, 1'b0, 0, bits);

        load('h1E7);
        run_frame(FRAME_BITS + 2, 1'b0, 0, bits);
        check("cnt_saturate", 32'(dut.cnt), FRAME_BITS);

        load('h123);
        run_frame(FRAME_BITS, 1'b0, 0, bits);
        run_frame(FRAME_BITS, 1'b0, 0, bits);
        check("stale_header", bits[FRAME_BITS-1 -: LEAD_ZEROS],
              STALE_EN ? 3 : 0);
        check("stale_flag", 32'(stale), 32'(STALE_EN));
        load('h0F0);
        run_frame(FRAME_BITS, 1'b0, 0, bits);
        check("stale_sticky", 32'(stale), 32'(STALE_EN));

        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(0, 2) != 0)
                load(int'($urandom_range(0, 1023)));
            case ($urandom_range(0, 3))
                0: n = int'($urandom_range(1, FRAME_BITS + 3));
                default: n = FRAME_BITS;
            endcase
            run_frame(n, ($urandom_range(0, 3) == 0),
                      int'($urandom_range(0, 1023)), bits);
        end

        // Asynchronous reset in the middle of a frame.
        load('h1C3);
        @(negedge clk);
        cs_n = 1'b0;
        repeat (5) @(negedge clk);
        sck = 1'b1;
        repeat (4) @(negedge clk);
        check("busy_before_rst", 32'(busy), 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_oe", 32'(miso_oe), 0);
        check("arst_miso", 32'(miso), 0);
        check("arst_fresh", 32'(fresh), 0);
        check("arst_stale", 32'(stale), 0);
        @(negedge clk);
        sck = 1'b0;
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_buf = 0;
        m_fresh = 1'b0;
        m_stale = 1'b0;
        repeat (3) @(negedge clk);
        run_frame(FRAME_BITS, 1'b0, 0, bits);

        repeat (10) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
